// File: rtl/alu_seq_param.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_param
//  Purpose  : Handshaked ALU with registered results/flags. Arithmetic, shift
//             and logic ops complete in one cycle; multiply is an iterative
//             shift-add (unsigned or signed) producing a 2*WIDTH product.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_param #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out0,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             N,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     out_q, out_d, out0_q, out0_d;
  logic                 cy_q, cy_d, ov_q, ov_d, zero_q, zero_d, n_q, n_d, err_q, err_d;

  // Single-cycle datapath terms, evaluated on the live inputs at accept time
  logic [SHW-1:0]       w_sh;
  logic [WIDTH-1:0]     w_opb;
  logic [WIDTH:0]       w_sum, w_dif;
  logic [WIDTH:0]       w_shl, w_shr;
  logic signed [WIDTH:0] w_sra;
  logic [WIDTH-1:0]     w_sla_chk;
  logic [WIDTH-1:0]     w_res;
  logic                 w_cy, w_ov, w_ill;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0]   w_acc_nxt, w_prod;

  // inc/dec reuse the add/sub paths with a constant second operand
  assign w_opb = op1[0] ? WIDTH'(1) : in1;
  assign w_sum = {1'b0, in0} + {1'b0, w_opb};
  assign w_dif = {1'b0, in0} - {1'b0, w_opb};   // MSB is the borrow

  // One guard bit beyond the word catches the last bit shifted out (0 when sh==0)
  assign w_sh      = in1[SHW-1:0];
  assign w_shl     = {1'b0, in0} << w_sh;
  assign w_shr     = {in0, 1'b0} >> w_sh;
  assign w_sra     = $signed({in0, 1'b0}) >>> w_sh;
  // SLA overflows unless shifting back arithmetically restores the operand
  assign w_sla_chk = $signed(w_shl[WIDTH-1:0]) >>> w_sh;

  // Multiply operates on magnitudes; sign is reapplied to the full product
  assign w_a_mag = (op1[0] && in0[WIDTH-1]) ? -in0 : in0;
  assign w_b_mag = (op1[0] && in1[WIDTH-1]) ? -in1 : in1;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign out0      = out0_q;
  assign carryout  = cy_q;
  assign overflow  = ov_q;
  assign zero      = zero_q;
  assign N         = n_q;
  assign err       = err_q;

  // Opcode decode for the single-cycle classes; illegal codes yield all zeros
  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    w_ov  = 1'b0;
    w_ill = 1'b0;
    case (op)
      4'd0: begin
        if (op1 > 4'd3) begin
          w_ill = 1'b1;
        end else if (!op1[1]) begin
          w_res = w_sum[WIDTH-1:0];
          w_cy  = w_sum[WIDTH];
          w_ov  = (in0[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != in0[WIDTH-1]);
        end else begin
          w_res = w_dif[WIDTH-1:0];
          w_cy  = w_dif[WIDTH];
          w_ov  = (in0[WIDTH-1] != w_opb[WIDTH-1]) && (w_dif[WIDTH-1] != in0[WIDTH-1]);
        end
      end
      4'd1: begin
        case (op1)
          4'd0: begin w_res = w_shl[WIDTH-1:0]; w_cy = w_shl[WIDTH]; end
          4'd1: begin w_res = w_shr[WIDTH:1];   w_cy = w_shr[0];     end
          4'd2: begin w_res = w_sra[WIDTH:1];   w_cy = w_sra[0];     end
          4'd3: begin
            w_res = w_shl[WIDTH-1:0];
            w_cy  = w_shl[WIDTH];
            w_ov  = (w_sla_chk != in0);
          end
          default: w_ill = 1'b1;
        endcase
      end
      4'd2: begin
        case (op1)
          4'd0:    w_res = in0 & in1;
          4'd1:    w_res = in0 | in1;
          4'd2:    w_res = in0 ^ in1;
          4'd3:    w_res = {in0[WIDTH/2-1:0], in0[WIDTH-1:WIDTH/2]};
          4'd4:    w_res = ~in0;
          default: w_ill = 1'b1;
        endcase
      end
      4'd3:    w_ill = (op1 > 4'd1);
      default: w_ill = 1'b1;
    endcase
  end

  // Next-state, multiplier iteration and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    out_d    = out_q;
    out0_d   = out0_q;
    cy_d     = cy_q;
    ov_d     = ov_q;
    zero_d   = zero_q;
    n_d      = n_q;
    err_d    = err_q;
    w_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    w_prod    = neg_q ? -w_acc_nxt : w_acc_nxt;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == 4'd3 && op1 <= 4'd1) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, w_a_mag};
            mplier_d = w_b_mag;
            neg_d    = op1[0] & (in0[WIDTH-1] ^ in1[WIDTH-1]);
          end else begin
            state_d = S_DONE;
            out_d   = w_res;
            out0_d  = '0;
            cy_d    = w_cy;
            ov_d    = w_ov;
            err_d   = w_ill;
            n_d     = w_res[WIDTH-1];
            zero_d  = (w_res == '0);
          end
        end
      end
      S_MUL: begin
        acc_d    = w_acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d = S_DONE;
          out_d   = w_prod[WIDTH-1:0];
          out0_d  = w_prod[2*WIDTH-1:WIDTH];
          cy_d    = 1'b0;
          ov_d    = 1'b0;
          err_d   = 1'b0;
          n_d     = w_prod[2*WIDTH-1];
          zero_d  = (w_prod == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      out_q    <= '0;
      out0_q   <= '0;
      cy_q     <= 1'b0;
      ov_q     <= 1'b0;
      zero_q   <= 1'b0;
      n_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      out_q    <= out_d;
      out0_q   <= out0_d;
      cy_q     <= cy_d;
      ov_q     <= ov_d;
      zero_q   <= zero_d;
      n_q      <= n_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_param
//  Purpose  : Self-checking bench for alu_seq_param (WIDTH=32) with directed
//             cases and randomized ops against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_param;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [3:0]   op1 = '0;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out, out0;
  logic         carryout, overflow, zero, N, err;

  int checks = 0;
  int errors = 0;

  // Last result captured while out_valid was high; flags as {c,v,z,n,err}
  logic [W-1:0] lo, lo0;
  logic [4:0]   lfl;

  typedef struct packed {
    logic [31:0] o;
    logic [31:0] o0;
    logic c, v, z, n, e, m;
  } exp_t;

  always #5 clk = ~clk;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op1(op1), .in0(in0), .in1(in1),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out0(out0),
    .carryout(carryout), .overflow(overflow), .zero(zero), .N(N), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic and bit-by-bit shifting
  function automatic exp_t model(input logic [3:0] fop, input logic [3:0] fop1,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint sa, sb, sr;
    logic [63:0] p;
    logic [31:0] x, b2;
    int sh;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fop)
      4'd0: begin
        if (fop1 <= 4'd3) begin
          b2 = fop1[0] ? 32'd1 : b;
          if (!fop1[1]) begin
            p   = {32'b0, a} + {32'b0, b2};
            r.o = p[31:0];
            r.c = p[32];
            sr  = sa + longint'($signed(b2));
          end else begin
            r.o = a - b2;
            r.c = (a < b2);
            sr  = sa - longint'($signed(b2));
          end
          r.v = (sr != longint'($signed(r.o)));
        end else r.e = 1'b1;
      end
      4'd1: begin
        if (fop1 <= 4'd3) begin
          sh = int'(b[4:0]);
          x  = a;
          for (int i = 0; i < sh; i++) begin
            if (fop1 == 4'd0 || fop1 == 4'd3) begin
              r.c = x[31];
              x   = x << 1;
              if (fop1 == 4'd3 && (r.c != a[31] || x[31] != a[31])) r.v = 1'b1;
            end else if (fop1 == 4'd1) begin
              r.c = x[0];
              x   = x >> 1;
            end else begin
              r.c = x[0];
              x   = {x[31], x[31:1]};
            end
          end
          r.o = x;
        end else r.e = 1'b1;
      end
      4'd2: begin
        case (fop1)
          4'd0:    r.o = a & b;
          4'd1:    r.o = a | b;
          4'd2:    r.o = a ^ b;
          4'd3:    r.o = {a[15:0], a[31:16]};
          4'd4:    r.o = ~a;
          default: r.e = 1'b1;
        endcase
      end
      4'd3: begin
        if (fop1 <= 4'd1) begin
          r.m = 1'b1;
          if (fop1 == 4'd0) p = {32'b0, a} * {32'b0, b};
          else              p = sa * sb;
          r.o  = p[31:0];
          r.o0 = p[63:32];
        end else r.e = 1'b1;
      end
      default: r.e = 1'b1;
    endcase
    if (r.e) begin
      r.o = '0; r.o0 = '0; r.c = 1'b0; r.v = 1'b0; r.n = 1'b0; r.z = 1'b1;
    end else if (r.m) begin
      r.n = r.o0[31];
      r.z = ({r.o0, r.o} == 64'd0);
    end else begin
      r.n = r.o[31];
      r.z = (r.o == 32'd0);
    end
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op, check latency/result, optionally backpressure, then retire it
  task automatic do_op(input logic [3:0] fop, input logic [3:0] fop1,
                       input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int lat, exp_lat, unstable;
    logic [71:0] snap;
    string nm;
    e       = model(fop, fop1, a, b);
    exp_lat = e.m ? W + 1 : 1;
    nm      = $sformatf("op%0d.%0d a=%h b=%h", fop, fop1, a, b);
    check({nm, " in_ready_idle"}, in_ready, 1);
    op = fop; op1 = fop1; in0 = a; in1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    // Scrambled inputs with in_valid high must be ignored while busy
    op = 4'($urandom); op1 = 4'($urandom); in0 = $urandom; in1 = $urandom;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " out"}, out, e.o);
    check({nm, " out0"}, out0, e.o0);
    check({nm, " flags"}, {carryout, overflow, zero, N, err}, {e.c, e.v, e.z, e.n, e.e});
    check({nm, " in_ready_busy"}, in_ready, 0);
    lo = out; lo0 = out0; lfl = {carryout, overflow, zero, N, err};
    if (hold > 0) begin
      snap = {out_valid, in_ready, out, out0, carryout, overflow, zero, N, err, 1'b0};
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        op = 4'($urandom); in0 = $urandom; in1 = $urandom;
        if ({out_valid, in_ready, out, out0, carryout, overflow, zero, N, err, 1'b0} !== snap)
          unstable++;
      end
      check({nm, " hold_stable"}, unstable, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, " retire_valid"}, out_valid, 0);
    check({nm, " retire_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [3:0]  rop, rop1;
    logic [31:0] ra, rb;
    int seen;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out", out, 0);
    check("rst out0", out0, 0);
    check("rst flags", {carryout, overflow, zero, N, err}, 0);

    // Directed cases
    do_op(4'd0, 4'd0, 32'h0000_ABCD, 32'h7FFF_FFFF, 0);
    check("add out", lo, 32'h8000_ABCC);
    check("add flags", lfl, 5'b01010);
    do_op(4'd0, 4'd2, 32'h8111_1000, 32'h6101_0000, 0);
    check("sub out", lo, 32'h2010_1000);
    check("sub flags", lfl, 5'b01000);
    do_op(4'd0, 4'd2, 32'h0, 32'h0, 0);
    check("sub0 flags", lfl, 5'b00100);
    do_op(4'd0, 4'd3, 32'h0, 32'h1234, 0);
    check("dec out", lo, 32'hFFFF_FFFF);
    check("dec flags", lfl, 5'b10010);
    do_op(4'd1, 4'd1, 32'h0900_0020, 32'd7, 0);
    check("srl out", lo, 32'h0012_0000);
    do_op(4'd1, 4'd2, 32'h8000_0000, 32'd4, 0);
    check("sra out", lo, 32'hF800_0000);
    do_op(4'd2, 4'd3, 32'h5656_1111, 32'h0, 0);
    check("swap out", lo, 32'h1111_5656);
    do_op(4'd2, 4'd4, 32'd9, 32'h0, 0);
    check("not out", lo, 32'hFFFF_FFF6);
    do_op(4'd3, 4'd0, 32'h4000_0000, 32'd8, 0);
    check("umul out", lo, 32'h0);
    check("umul out0", lo0, 32'h2);
    check("umul zero", lfl[2], 0);
    do_op(4'd3, 4'd1, 32'hFFFF_FFFD, 32'd5, 10);
    check("smul out", lo, 32'hFFFF_FFF1);
    check("smul out0", lo0, 32'hFFFF_FFFF);
    check("smul N", lfl[1], 1);
    do_op(4'd0, 4'd0, 32'h1234_5678, 32'h1111_1111, 10);
    do_op(4'd2, 4'd7, 32'hDEAD_BEEF, 32'h1, 0);
    check("illegal out", lo, 32'h0);
    check("illegal flags", lfl, 5'b00101);

    // Randomized ops, including illegal codes and corner operands
    for (int i = 0; i < 60; i++) begin
      rop  = (i % 10 == 9) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      rop1 = 4'($urandom_range(0, 5));
      ra   = pick();
      rb   = pick();
      do_op(rop, rop1, ra, rb, (i % 7 == 0) ? 3 : 0);
    end

    // Leave a nonzero result registered, then reset in the middle of a multiply
    do_op(4'd2, 4'd1, 32'hA5A5_0F0F, 32'h0101_0101, 0);
    op = 4'd3; op1 = 4'd1; in0 = 32'hFFFF_FF00; in1 = 32'h0000_0123; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid-mul in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-rst in_ready", in_ready, 1);
    check("mid-rst out_valid", out_valid, 0);
    check("mid-rst out", out, 0);
    check("mid-rst out0", out0, 0);
    check("mid-rst flags", {carryout, overflow, zero, N, err}, 0);
    seen = 0;
    repeat (W + 5) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mid-rst no_valid", seen, 0);
    do_op(4'd3, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
